cnn_sdiv_seq_25s_10s: RTL and testbench

CNN_SDIV_SEQ_25S_10S -- requirements
Module: cnn_sdiv_seq_25s_10s

---
 rtl/cnn_sdiv_seq_25s_10s.sv | 166 ++++++++++++++++
 tb/tb_cnn_sdiv_seq_25s_10s.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cnn_sdiv_seq_25s_10s.sv
// ============================================================================
// Module      : cnn_sdiv_seq_25s_10s
// Description : Sequential signed divider, 25-bit dividend / 10-bit divisor,
//               saturated 14-bit quotient. Optional macro CNN_SDIV_ROUND_EN
//               selects round-half-away-from-zero instead of truncation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_sdiv_seq_25s_10s #(
    parameter int din0_WIDTH = 25,
    parameter int din1_WIDTH = 10,
    parameter int dout_WIDTH = 14
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ap_start,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    output logic                         ap_ready,
    output logic                         ap_done,
    output logic                         ap_idle,
    output logic signed [dout_WIDTH-1:0] dout,
    output logic signed [din1_WIDTH-1:0] rem,
    output logic                         div_zero,
    output logic                         ovf
);

    localparam int C_CW = $clog2(din0_WIDTH + 1);
    localparam logic [C_CW-1:0]       C_LAST   = C_CW'(din0_WIDTH - 1);
    localparam logic [din0_WIDTH-1:0] C_ONE0   = {{(din0_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [din1_WIDTH-1:0] C_ONE1   = {{(din1_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [dout_WIDTH-1:0] C_ONED   = {{(dout_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [din0_WIDTH:0]   C_POS_LIM = {{(din0_WIDTH-dout_WIDTH+2){1'b0}}, {(dout_WIDTH-1){1'b1}}};
    localparam logic [din0_WIDTH:0]   C_NEG_LIM = {{(din0_WIDTH-dout_WIDTH+1){1'b0}}, 1'b1, {(dout_WIDTH-1){1'b0}}};
    localparam logic [dout_WIDTH-1:0] C_DMAX   = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] C_DMIN   = {1'b1, {(dout_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    logic [din0_WIDTH-1:0]   r_q;      // dividend bits shift out, quotient bits shift in
    logic [din1_WIDTH:0]     r_prem;
    logic [din1_WIDTH-1:0]   r_dmag;
    logic                    r_s0;
    logic                    r_s1;
    logic                    r_dz;
    logic [C_CW-1:0]         r_cnt;
    logic [dout_WIDTH-1:0]   r_dout;
    logic [din1_WIDTH-1:0]   r_rem;
    logic                    r_div_zero;
    logic                    r_ovf;

    logic [din0_WIDTH-1:0]   w_d0u;
    logic [din1_WIDTH-1:0]   w_d1u;
    logic [din0_WIDTH-1:0]   w_mag0;
    logic [din1_WIDTH-1:0]   w_mag1;
    logic [din1_WIDTH:0]     w_sh;
    logic [din1_WIDTH:0]     w_dext;
    logic                    w_ge;
    logic                    w_inc;
    logic [din0_WIDTH:0]     w_qr;
    logic                    w_neg;
    logic                    w_ovf;
    logic [dout_WIDTH-1:0]   w_qfix;
    logic [din1_WIDTH-1:0]   w_remfix;

    // Magnitudes are unsigned so that -2^24 and -512 stay representable
    assign w_d0u  = din0;
    assign w_d1u  = din1;
    assign w_mag0 = din0[din0_WIDTH-1] ? (~w_d0u + C_ONE0) : w_d0u;
    assign w_mag1 = din1[din1_WIDTH-1] ? (~w_d1u + C_ONE1) : w_d1u;

    assign w_sh   = {r_prem[din1_WIDTH-1:0], r_q[din0_WIDTH-1]};
    assign w_dext = {1'b0, r_dmag};
    assign w_ge   = (w_sh >= w_dext);

`ifdef CNN_SDIV_ROUND_EN
    assign w_inc = ({r_prem[din1_WIDTH-1:0], 1'b0} >= w_dext);
`else
    assign w_inc = 1'b0;
`endif

    assign w_qr  = {1'b0, r_q} + {{din0_WIDTH{1'b0}}, w_inc};
    assign w_neg = r_s0 ^ r_s1;
    assign w_ovf = w_neg ? (w_qr > C_NEG_LIM) : (w_qr > C_POS_LIM);

    always_comb begin
        w_qfix   = '0;
        w_remfix = '0;
        if (r_dz) begin
            w_qfix = r_s0 ? C_DMIN : C_DMAX;
        end else if (w_ovf) begin
            w_qfix = w_neg ? C_DMIN : C_DMAX;
        end else begin
            w_qfix   = w_neg ? (~w_qr[dout_WIDTH-1:0] + C_ONED) : w_qr[dout_WIDTH-1:0];
            w_remfix = r_s0 ? (~r_prem[din1_WIDTH-1:0] + C_ONE1) : r_prem[din1_WIDTH-1:0];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state    <= S_IDLE;
            r_q        <= '0;
            r_prem     <= '0;
            r_dmag     <= '0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_dz       <= 1'b0;
            r_cnt      <= '0;
            r_dout     <= '0;
            r_rem      <= '0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_q     <= w_mag0;
                        r_prem  <= '0;
                        r_dmag  <= w_mag1;
                        r_s0    <= din0[din0_WIDTH-1];
                        r_s1    <= din1[din1_WIDTH-1];
                        r_dz    <= (din1 == '0);
                        r_cnt   <= '0;
                        r_state <= (din1 == '0) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    r_prem <= w_ge ? (w_sh - w_dext) : w_sh;
                    r_q    <= {r_q[din0_WIDTH-2:0], w_ge};
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_dout     <= w_qfix;
                    r_rem      <= w_remfix;
                    r_div_zero <= r_dz;
                    r_ovf      <= r_dz ? 1'b0 : w_ovf;
                    r_state    <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ap_ready = (r_state == S_IDLE) && ap_start;
    assign ap_idle  = (r_state == S_IDLE);
    assign ap_done  = (r_state == S_DONE);
    assign dout     = r_dout;
    assign rem      = r_rem;
    assign div_zero = r_div_zero;
    assign ovf      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cnn_sdiv_seq_25s_10s.sv
// ============================================================================
// Module      : tb_cnn_sdiv_seq_25s_10s
// Description : Directed self-checking bench for cnn_sdiv_seq_25s_10s.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnn_sdiv_seq_25s_10s;

    logic               ap_clk;
    logic               ap_rst_n;
    logic               ap_start;
    logic signed [24:0] din0;
    logic signed [9:0]  din1;
    logic               ap_ready;
    logic               ap_done;
    logic               ap_idle;
    logic signed [13:0] dout;
    logic signed [9:0]  rem;
    logic               div_zero;
    logic               ovf;

    int r_errs;
    int r_checks;

    cnn_sdiv_seq_25s_10s u_dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .din0     (din0),
        .din1     (din1),
        .ap_ready (ap_ready),
        .ap_done  (ap_done),
        .ap_idle  (ap_idle),
        .dout     (dout),
        .rem      (rem),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

`ifdef CNN_SDIV_ROUND_EN
    localparam bit C_RND = 1'b1;
`else
    localparam bit C_RND = 1'b0;
`endif

    task automatic check(input string tag, input int got, input int exp);
        r_checks++;
        if (got !== exp) begin
            r_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input int d0, input int d1,
                          input int q, input int r, input int dz, input int ov, input int lat);
        int n;
        @(negedge ap_clk);
        din0     = d0[24:0];
        din1     = d1[9:0];
        ap_start = 1'b1;
        #1 check({tag, ".ready"}, int'(ap_ready), 1);
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        din0     = ~din0;
        din1     = 10'sd3;
        n = 0;
        while (!ap_done && n < 60) begin
            @(negedge ap_clk);
            n++;
        end
        check({tag, ".lat"},  n, lat);
        check({tag, ".dout"}, int'(dout), q);
        check({tag, ".rem"},  int'(rem), r);
        check({tag, ".dz"},   int'(div_zero), dz);
        check({tag, ".ovf"},  int'(ovf), ov);
        @(negedge ap_clk);
        check({tag, ".done_pulse"}, int'(ap_done), 0);
        check({tag, ".idle"}, int'(ap_idle), 1);
    endtask

    initial begin
        int rdy_t[$];
        int done_t[$];
        int done_q[$];
        int n_done;

        r_errs   = 0;
        r_checks = 0;
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        din0     = '0;
        din1     = '0;

        repeat (2) @(negedge ap_clk);
        check("reset.idle",  int'(ap_idle), 1);
        check("reset.ready", int'(ap_ready), 0);
        check("reset.done",  int'(ap_done), 0);
        check("reset.dout",  int'(dout), 0);
        ap_rst_n = 1'b1;

        run_op("p1000_7",  1000, 7,  C_RND ? 143 : 142,  6, 0, 0, 27);
        run_op("n1000_7", -1000, 7,  C_RND ? -143 : -142, -6, 0, 0, 27);
        run_op("sat_pos", 100000, 3, 8191, 0, 0, 1, 27);
        run_op("sat_min", -16777216, -1, 8191, 0, 0, 1, 27);
        run_op("dz_pos", 5, 0, 8191, 0, 1, 0, 2);
        run_op("dz_neg", -5, 0, -8192, 0, 1, 0, 2);
        run_op("neg_edge", -8192, 1, -8192, 0, 0, 0, 27);
        run_op("pos_over", 8192, 1, 8191, 0, 0, 1, 27);
        run_op("half_neg", -16383, 2, C_RND ? -8192 : -8191, -1, 0, 0, 27);
        run_op("half_pos", 16383, 2, 8191, C_RND ? 0 : 1, 0, C_RND ? 1 : 0, 27);
        run_op("div_m512", 1000, -512, C_RND ? -2 : -1, 488, 0, 0, 27);
        run_op("seven_m2", 7, -2, C_RND ? -4 : -3, 1, 0, 0, 27);

        // Reset in the middle of CALC
        @(negedge ap_clk);
        din0 = 25'sd1000; din1 = 10'sd7; ap_start = 1'b1;
        @(posedge ap_clk);
        #1 ap_start = 1'b0;
        repeat (10) @(negedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        check("mid_rst.idle", int'(ap_idle), 1);
        check("mid_rst.done", int'(ap_done), 0);
        check("mid_rst.dout", int'(dout), 0);
        check("mid_rst.rem",  int'(rem), 0);
        check("mid_rst.ovf",  int'(ovf), 0);
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge ap_clk);
            if (ap_done) n_done++;
        end
        check("mid_rst.no_done", n_done, 0);
        run_op("after_rst", 1000, 7, C_RND ? 143 : 142, 6, 0, 0, 27);

        // Continuous start with inputs changed after capture
        @(negedge ap_clk);
        din0 = 25'sd1000; din1 = 10'sd7; ap_start = 1'b1;
        for (int t = 0; t <= 60; t++) begin
            if (t > 0) @(negedge ap_clk);
            #1;
            if (ap_ready) rdy_t.push_back(t);
            if (ap_done) begin
                done_t.push_back(t);
                done_q.push_back(int'(dout));
            end
            if (t == 1) begin
                din0 = 25'sd60;
                din1 = 10'sd4;
            end
        end
        ap_start = 1'b0;
        check("cont.ready_cnt", rdy_t.size(), 3);
        check("cont.done_cnt",  done_t.size(), 2);
        if (rdy_t.size() == 3) begin
            check("cont.ready_t1", rdy_t[1], 28);
            check("cont.ready_t2", rdy_t[2], 56);
        end
        if (done_t.size() == 2) begin
            check("cont.done_t0", done_t[0], 27);
            check("cont.dout0",   done_q[0], C_RND ? 143 : 142);
            check("cont.done_t1", done_t[1], 55);
            check("cont.dout1",   done_q[1], 15);
        end
        repeat (40) @(negedge ap_clk);
        check("cont.final_idle", int'(ap_idle), 1);

        $display("Result: errors=%0d of %0d checks", r_errs, r_checks);
        $finish;
    end

endmodule

`default_nettype wire
